// File: rtl/matmul_seq_fsm_pkg.sv
// rtl/matmul_seq_fsm_pkg.sv - shared opcodes, state encoding and width helpers for matmul_seq_fsm
package matmul_pkg;

  // Host command opcodes
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  // Sequencer state encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STORE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Default block geometry
  localparam int DEF_NUM_IN_BLOCKS  = 8;
  localparam int DEF_NUM_OUT_BLOCKS = 4;
  localparam int DEF_ROWS           = 2;
  localparam int DEF_COLS           = 2;
  localparam int DEF_BLK_W          = 3;

  // Index width for a range of n values; never narrower than one bit
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Shared widths for the default geometry
  localparam int DEF_SEL_W = width_of(DEF_NUM_OUT_BLOCKS);
  localparam int DEF_ROW_W = width_of(DEF_ROWS);
  localparam int DEF_COL_W = width_of(DEF_COLS);

endpackage

// File: rtl/matmul_seq_fsm_if.sv
// rtl/matmul_seq_fsm_if.sv - host/datapath handshake bundle for matmul_seq_fsm (abort port under MATMUL_SEQ_ABORT_EN)
interface matmul_seq_fsm_if
  import matmul_pkg::*;
#(
  parameter int NUM_IN_BLOCKS  = DEF_NUM_IN_BLOCKS,
  parameter int NUM_OUT_BLOCKS = DEF_NUM_OUT_BLOCKS,
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int BLK_W          = DEF_BLK_W
) ();

  localparam int SEL_W = width_of(NUM_OUT_BLOCKS);
  localparam int ROW_W = width_of(ROWS);
  localparam int COL_W = width_of(COLS);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [BLK_W-1:0]         cmd_block;
  logic                     in_valid;
  logic                     in_ready;
  logic                     out_ready;
  logic                     out_valid;
  logic [NUM_IN_BLOCKS-1:0] block_we;
  logic                     data_we;
  logic [SEL_W-1:0]         jklm_select;
  logic [ROW_W-1:0]         row;
  logic [COL_W-1:0]         column;
  logic                     busy;
  logic                     done;
  logic                     err;
`ifdef MATMUL_SEQ_ABORT_EN
  logic                     abort;

  modport master (
    output cmd_valid, cmd_op, cmd_block, in_valid, out_ready, abort,
    input  cmd_ready, in_ready, out_valid, block_we, data_we, jklm_select,
           row, column, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_block, in_valid, out_ready, abort,
    output cmd_ready, in_ready, out_valid, block_we, data_we, jklm_select,
           row, column, busy, done, err
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_block, in_valid, out_ready,
    input  cmd_ready, in_ready, out_valid, block_we, data_we, jklm_select,
           row, column, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_block, in_valid, out_ready,
    output cmd_ready, in_ready, out_valid, block_we, data_we, jklm_select,
           row, column, busy, done, err
  );
`endif

endinterface

// File: rtl/matmul_seq_fsm_rc_counter.sv
// rtl/matmul_seq_fsm_rc_counter.sv - row-major ROWS x COLS beat counter with clear, advance and last-beat flag
module rc_counter
  import matmul_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      advance,
  output logic [width_of(ROWS)-1:0] row,
  output logic [width_of(COLS)-1:0] column,
  output logic                      last
);

  localparam int ROW_W = width_of(ROWS);
  localparam int COL_W = width_of(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  // Column steps every beat; row steps when the column wraps; both wrap to 0 after the final beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row    <= '0;
      column <= '0;
    end else if (clear) begin
      row    <= '0;
      column <= '0;
    end else if (advance) begin
      if (column == COL_LAST) begin
        column <= '0;
        row    <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        column <= column + 1'b1;
      end
    end
  end

  // Current position is the final beat of the block
  assign last = (row == ROW_LAST) && (column == COL_LAST);

endmodule

// File: rtl/matmul_seq_fsm.sv
// rtl/matmul_seq_fsm.sv - matrix-multiply load/store sequencing FSM (optional abort via MATMUL_SEQ_ABORT_EN)
module matmul_seq_fsm
  import matmul_pkg::*;
#(
  parameter int NUM_IN_BLOCKS  = DEF_NUM_IN_BLOCKS,
  parameter int NUM_OUT_BLOCKS = DEF_NUM_OUT_BLOCKS,
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int BLK_W          = DEF_BLK_W
) (
  input logic            clk,
  input logic            reset,
  matmul_seq_fsm_if.slave bus
);

  localparam int SEL_W = width_of(NUM_OUT_BLOCKS);

  state_t           state;
  state_t           state_next;
  logic [BLK_W-1:0] blk_q;
  logic             accept;
  logic             load_ok;
  logic             store_ok;
  logic             abort_hit;
  logic             beat;
  logic             clear;
  logic             last;

  assign accept   = (state == ST_IDLE) && bus.cmd_valid;
  assign load_ok  = 32'(bus.cmd_block) < NUM_IN_BLOCKS;
  assign store_ok = 32'(bus.cmd_block) < NUM_OUT_BLOCKS;

`ifdef MATMUL_SEQ_ABORT_EN
  // Abort only has meaning while a block walk is in progress
  assign abort_hit = bus.abort && ((state == ST_LOAD) || (state == ST_STORE));
`else
  assign abort_hit = 1'b0;
`endif

  // A beat moves when the active side handshakes and no abort cancels it
  assign beat  = !abort_hit &&
                 (((state == ST_LOAD) && bus.in_valid) ||
                  ((state == ST_STORE) && bus.out_ready));

  // Counters restart on every new command and after an abort so IDLE reads (0,0)
  assign clear = accept || abort_hit;

  rc_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_rc_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .advance (beat),
    .row     (bus.row),
    .column  (bus.column),
    .last    (last)
  );

  // Target block captured with the command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_q <= '0;
    end else if (accept) begin
      blk_q <= bus.cmd_block;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: command dispatch in IDLE, walk until the last beat, single-cycle DONE/ERR
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_NOP:   state_next = ST_DONE;
            OP_LOAD:  state_next = load_ok ? ST_LOAD : ST_ERR;
            OP_STORE: state_next = store_ok ? ST_STORE : ST_ERR;
            default:  state_next = ST_ERR;
          endcase
        end
      end
      ST_LOAD, ST_STORE: begin
        if (abort_hit) begin
          state_next = ST_IDLE;
        end else if (beat && last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode; an aborting cycle also drops the handshakes so neither side sees a transfer
  always_comb begin
    bus.cmd_ready   = 1'b0;
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.block_we    = '0;
    bus.data_we     = 1'b0;
    bus.jklm_select = '0;
    bus.busy        = (state != ST_IDLE);
    bus.done        = 1'b0;
    bus.err         = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
      end
      ST_LOAD: begin
        bus.in_ready = !abort_hit;
        if (bus.in_valid && !abort_hit) begin
          bus.block_we = NUM_IN_BLOCKS'(1) << blk_q;
        end
      end
      ST_STORE: begin
        bus.out_valid   = !abort_hit;
        bus.data_we     = !abort_hit;
        bus.jklm_select = blk_q[SEL_W-1:0];
      end
      ST_DONE: begin
        bus.done = 1'b1;
      end
      ST_ERR: begin
        bus.err = 1'b1;
      end
      default: begin
        bus.busy = 1'b1;
      end
    endcase
    if (abort_hit) begin
      bus.err = 1'b1;
    end
  end

endmodule

// File: tb/tb_matmul_seq_fsm.sv
// tb/tb_matmul_seq_fsm.sv - self-checking bench for matmul_seq_fsm (abort steps under MATMUL_SEQ_ABORT_EN)
module tb_matmul_seq_fsm;
  import matmul_pkg::*;

  localparam int NIN  = DEF_NUM_IN_BLOCKS;
  localparam int NOUT = DEF_NUM_OUT_BLOCKS;
  localparam int R    = DEF_ROWS;
  localparam int C    = DEF_COLS;
  localparam int BW   = DEF_BLK_W;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  matmul_seq_fsm_if #(.NUM_IN_BLOCKS(NIN), .NUM_OUT_BLOCKS(NOUT), .ROWS(R), .COLS(C), .BLK_W(BW)) bus ();
  matmul_seq_fsm #(.NUM_IN_BLOCKS(NIN), .NUM_OUT_BLOCKS(NOUT), .ROWS(R), .COLS(C), .BLK_W(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  matmul_seq_fsm_if #(.NUM_IN_BLOCKS(6), .NUM_OUT_BLOCKS(NOUT), .ROWS(R), .COLS(C), .BLK_W(BW)) bus6 ();
  matmul_seq_fsm #(.NUM_IN_BLOCKS(6), .NUM_OUT_BLOCKS(NOUT), .ROWS(R), .COLS(C), .BLK_W(BW)) dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus6.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_err"},       32'(bus.err),       32'd0);
    chk({tag, "_block_we"},  32'(bus.block_we),  32'd0);
    chk({tag, "_data_we"},   32'(bus.data_we),   32'd0);
  endtask

  // One command end to end; the model tracks the beat index k and derives row/column from it
  task automatic run_cmd(input logic [1:0] op, input int blk, input int mode);
    int   n = R * C;
    int   k;
    int   cyc;
    logic v;
    bit   walk_load;
    bit   walk_store;
    walk_load  = (op == OP_LOAD)  && (blk < NIN);
    walk_store = (op == OP_STORE) && (blk < NOUT);

    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_block = BW'(blk);
    #1;
    chk("accept_ready", 32'(bus.cmd_ready), 32'd1);

    // Keep offering commands while busy: they must be ignored
    @(negedge clk);
    bus.cmd_op    = 2'($urandom_range(0, 3));
    bus.cmd_block = BW'($urandom_range(0, 7));

    if (walk_load || walk_store) begin
      k   = 0;
      cyc = 0;
      while (k < n) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = ((cyc % 2) == 0);
          2:       v = (cyc >= 2);
          default: v = (cyc >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
        if (walk_load) bus.in_valid = v;
        else           bus.out_ready = v;
        #1;
        chk("walk_busy",   32'(bus.busy),   32'd1);
        chk("walk_row",    32'(bus.row),    32'(k / C));
        chk("walk_column", 32'(bus.column), 32'(k % C));
        chk("walk_done",   32'(bus.done),   32'd0);
        chk("walk_ready",  32'(bus.cmd_ready), 32'd0);
        if (walk_load) begin
          chk("load_in_ready", 32'(bus.in_ready), 32'd1);
          chk("load_block_we", 32'(bus.block_we), v ? (32'd1 << blk) : 32'd0);
          chk("load_data_we",  32'(bus.data_we),  32'd0);
        end else begin
          chk("store_out_valid", 32'(bus.out_valid),   32'd1);
          chk("store_data_we",   32'(bus.data_we),     32'd1);
          chk("store_select",    32'(bus.jklm_select), 32'(blk));
          chk("store_block_we",  32'(bus.block_we),    32'd0);
        end
        if (v) k++;
        cyc++;
        @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
    end

    #1;
    if ((op == OP_NOP) || walk_load || walk_store) begin
      chk("end_done", 32'(bus.done), 32'd1);
      chk("end_err",  32'(bus.err),  32'd0);
    end else begin
      chk("end_err",  32'(bus.err),  32'd1);
      chk("end_done", 32'(bus.done), 32'd0);
    end
    chk("end_busy",     32'(bus.busy),      32'd1);
    chk("end_ready",    32'(bus.cmd_ready), 32'd0);
    chk("end_block_we", 32'(bus.block_we),  32'd0);
    chk("end_data_we",  32'(bus.data_we),   32'd0);
    chk("end_row",      32'(bus.row),       32'd0);
    chk("end_column",   32'(bus.column),    32'd0);

    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    check_idle("back_idle");
  endtask

  initial begin
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = OP_NOP;
    bus.cmd_block  = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus6.cmd_valid = 1'b0;
    bus6.cmd_op    = OP_NOP;
    bus6.cmd_block = '0;
    bus6.in_valid  = 1'b0;
    bus6.out_ready = 1'b0;
`ifdef MATMUL_SEQ_ABORT_EN
    bus.abort      = 1'b0;
    bus6.abort     = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    #1;
    check_idle("reset");
    chk("reset_row",    32'(bus.row),         32'd0);
    chk("reset_column", 32'(bus.column),      32'd0);
    chk("reset_select", 32'(bus.jklm_select), 32'd0);
    reset = 1'b0;

    // Reset in the middle of a LOAD after two beats
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LOAD;
    bus.cmd_block = 3'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle("midreset");
    chk("midreset_row",    32'(bus.row),    32'd0);
    chk("midreset_column", 32'(bus.column), 32'd0);
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_idle("after_reset");

    // Directed plan
    run_cmd(OP_LOAD,  0, 0);
    run_cmd(OP_LOAD,  7, 1);
    run_cmd(OP_STORE, 3, 2);
    run_cmd(OP_STORE, 5, 0);
    run_cmd(OP_RSVD,  1, 0);
    run_cmd(OP_NOP,   0, 0);

    // LOAD block 7 is out of range on the six-block variant
    @(negedge clk);
    bus6.cmd_valid = 1'b1;
    bus6.cmd_op    = OP_LOAD;
    bus6.cmd_block = 3'd7;
    #1;
    chk("six_ready", 32'(bus6.cmd_ready), 32'd1);
    @(negedge clk);
    bus6.cmd_valid = 1'b0;
    #1;
    chk("six_err",      32'(bus6.err),      32'd1);
    chk("six_block_we", 32'(bus6.block_we), 32'd0);
    chk("six_in_ready", 32'(bus6.in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("six_err_clear", 32'(bus6.err),       32'd0);
    chk("six_idle",      32'(bus6.cmd_ready), 32'd1);

    // Randomized commands against the model
    for (int i = 0; i < 16; i++) begin
      run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

`ifdef MATMUL_SEQ_ABORT_EN
    // Abort during the third STORE beat
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_STORE;
    bus.cmd_block = 3'd1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    #1;
    chk("abort_data_we", 32'(bus.data_we), 32'd0);
    chk("abort_err",     32'(bus.err),     32'd1);
    chk("abort_done",    32'(bus.done),    32'd0);
    chk("abort_row",     32'(bus.row),     32'd1);
    @(negedge clk);
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_idle("post_abort");
    chk("post_abort_row",    32'(bus.row),    32'd0);
    chk("post_abort_column", 32'(bus.column), 32'd0);

    // Abort while idle does nothing
    @(negedge clk);
    bus.abort = 1'b1;
    #1;
    check_idle("idle_abort");
    @(negedge clk);
    bus.abort = 1'b0;
    run_cmd(OP_LOAD, 4, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_seq_fsm.md
Name: matmul_seq_fsm

Overview:
Sequencing controller for the matrix-multiply datapath. It is the parametrised successor to the combinational command decoder.
- Accepts one command per handshake.
- Walks a block of ROWS x COLS elements one beat at a time, row-major, generating block write enables (load) or output-select/data_we (store) plus row/column addresses.
- Sits between the host command interface and the A..H input block RAMs / J..M output blocks.

Parameters:
- NUM_IN_BLOCKS, 8, number of loadable input blocks (A..H); one write enable each.
- NUM_OUT_BLOCKS, 4, number of storable output blocks (J..M).
- ROWS, 2, rows per block (>=2).
- COLS, 2, columns per block (>=2).
- BLK_W, 3, width of cmd_block; must satisfy 2**BLK_W >= NUM_IN_BLOCKS and 2**BLK_W >= NUM_OUT_BLOCKS.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FSM can accept a command.
- cmd_op  in  2  opcode: NOP=00, LOAD=01, STORE=10, RSVD=11.
- cmd_block  in  BLK_W  target block index.
- in_valid  in  1  load data beat present.
- in_ready  out  1  FSM consuming load beats.
- out_ready  in  1  sink accepts store beat.
- out_valid  out  1  store beat presented.
- block_we  out  NUM_IN_BLOCKS  one-hot input-block write enable.
- data_we  out  1  store-path write enable.
- jklm_select  out  clog2(NUM_OUT_BLOCKS)  output-block mux select.
- row  out  clog2(ROWS)  current row.
- column  out  clog2(COLS)  current column.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (async, immediate, including mid-operation):
  - state=IDLE; row=0, column=0, latched block=0.
  - Every output 0 except cmd_ready=1.
  - No done is generated.
- States: IDLE, LOAD, STORE, DONE, ERR.
- IDLE:
  - cmd_ready=1; a command is accepted when cmd_valid&&cmd_ready at a rising edge; cmd_block is latched.
  - LOAD with cmd_block<NUM_IN_BLOCKS -> LOAD.
  - STORE with cmd_block<NUM_OUT_BLOCKS -> STORE.
  - NOP -> DONE.
  - RSVD or out-of-range block -> ERR.
  - row/column reset to 0 on accept.
- LOAD:
  - in_ready=1; block_we[latched]=in_valid (combinational), all other bits 0; data_we=0.
  - A beat transfers when in_valid=1. column increments; on column==COLS-1 it wraps to 0 and row increments.
  - Beat at (ROWS-1, COLS-1) -> DONE.
  - in_valid=0 stalls: counters hold, no we.
- STORE:
  - out_valid=1, data_we=1, jklm_select=latched block, block_we=0.
  - A beat transfers when out_ready=1; counter rules as LOAD.
  - Last beat -> DONE.
- DONE: done=1 for exactly one cycle, cmd_ready=0, then -> IDLE.
- ERR: err=1 for exactly one cycle, no enables asserted, then -> IDLE.
- Latency:
  - First beat may transfer the cycle after accept.
  - cmd_ready returns 2 cycles after the last beat.
  - A LOAD with in_valid held high takes ROWS*COLS+2 cycles from accept to the next cmd_ready.
- row/column hold their final values (0,0 after wrap) in DONE. They are not driven to meaningful values in IDLE; they read 0.
- cmd_valid is ignored while busy. No command queuing.

Optional Feature:
- Macro: MATMUL_SEQ_ABORT_EN.
- With the macro defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD or STORE -> IDLE at the next edge. The beat in that cycle is not counted; we/data_we are forced to 0 in the abort cycle.
  - No done; err pulses for one cycle.
  - abort in IDLE/DONE/ERR has no effect.
- Without the macro: port absent, behaviour exactly as above.

Decomposition:
- Package matmul_pkg holds:
  - opcode constants OP_NOP/OP_LOAD/OP_STORE/OP_RSVD;
  - state encoding typedef (IDLE=0, LOAD=1, STORE=2, DONE=3, ERR=4);
  - shared widths for row/column/select.
- One sub-module, rc_counter:
  - parametrised ROWS/COLS row-major counter with clear, advance, last-beat flag and async reset;
  - instantiated once.

Test Plan:
- Reset mid-LOAD (after 2 beats) -> same cycle: block_we=0, busy=0, cmd_ready=1, row=0, column=0; no done.
- LOAD block 0, in_valid held high -> block_we=8'b00000001 for 4 consecutive cycles; (row,column) = (0,0),(0,1),(1,0),(1,1); done pulse 1 cycle later; cmd_ready high the cycle after.
- LOAD block 7 with in_valid toggling 1,0,1,0,... -> block_we=8'b10000000 only on in_valid cycles; counters hold on stall; done after the 4th accepted beat.
- STORE block 3, out_ready low 2 cycles then high -> data_we=1, out_valid=1, jklm_select=2'b11 throughout; no advance while out_ready=0; 4 beats then done; block_we=0 throughout.
- Illegal commands: LOAD block 7 with NUM_IN_BLOCKS=6, STORE block 5, and op=RSVD -> err pulse 1 cycle each; no we/data_we; back to IDLE. NOP -> done pulse, no beats.
- With MATMUL_SEQ_ABORT_EN: abort in 3rd STORE beat -> data_we=0 that cycle, IDLE next edge, err=1, done=0.
